iob_cache_write_buffer: RTL and testbench

- Write-through buffer between the cache front-end/controller and the AXI write channel.
- Queues single-word write requests (word address, data, byte strobe) and presents them in FIFO order on a valid/ready interface that matches the write channel's valid/addr/wdata/wstrb/ready inputs.
- Reports empty/full/level so the controller can stall on full and detect drain-complete for flush and ordering.

---
 rtl/iob_cache_write_buffer_if.sv | 40 ++++
 rtl/iob_cache_write_buffer.sv | 74 +++++++
 tb/tb_iob_cache_write_buffer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/iob_cache_write_buffer_if.sv
// Bundle between the write-through buffer, its controller (push side) and the
// AXI write channel (pop side), plus the buffer's occupancy/status outputs.
interface iob_cache_write_buffer_if #(
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 32,
    parameter int DEPTH_W = 2
);
    localparam int FE_NBYTES   = DATA_W / 8;
    localparam int FE_NBYTES_W = $clog2(FE_NBYTES);
    localparam int WORD_W      = ADDR_W - FE_NBYTES_W;

    logic                 push_i;
    logic [WORD_W-1:0]    push_addr_i;
    logic [DATA_W-1:0]    push_wdata_i;
    logic [FE_NBYTES-1:0] push_wstrb_i;
    logic                 full_o;

    // Handshake: the head {addr_o, wdata_o, wstrb_o} transfers on a rising clk_i
    // where valid_o & ready_i; while valid_o & ~ready_i the head is held stable.
    // A push transfers on a rising edge where push_i & ~full_o, else it is dropped.
    logic                 valid_o;
    logic [WORD_W-1:0]    addr_o;
    logic [DATA_W-1:0]    wdata_o;
    logic [FE_NBYTES-1:0] wstrb_o;
    logic                 ready_i;

    logic                 empty_o;
    logic [DEPTH_W:0]     level_o;
    logic                 overflow_o;

    modport slave (
        input  push_i, push_addr_i, push_wdata_i, push_wstrb_i, ready_i,
        output full_o, valid_o, addr_o, wdata_o, wstrb_o, empty_o, level_o, overflow_o
    );

    modport master (
        output push_i, push_addr_i, push_wdata_i, push_wstrb_i, ready_i,
        input  full_o, valid_o, addr_o, wdata_o, wstrb_o, empty_o, level_o, overflow_o
    );
endinterface

// File: rtl/iob_cache_write_buffer.sv
// Write-through FIFO between the cache controller and the AXI write channel.
// First-word fall-through head, registered level counter, sticky overflow flag.
module iob_cache_write_buffer #(
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 32,
    parameter int DEPTH_W = 2
) (
    input  logic                    clk_i,
    input  logic                    reset,
    iob_cache_write_buffer_if.slave bus
);
    localparam int FE_NBYTES   = DATA_W / 8;
    localparam int FE_NBYTES_W = $clog2(FE_NBYTES);
    localparam int WORD_W      = ADDR_W - FE_NBYTES_W;
    localparam int DEPTH       = 2 ** DEPTH_W;
    localparam logic [DEPTH_W:0] ONE = {{DEPTH_W{1'b0}}, 1'b1};

    logic [WORD_W-1:0]    addr_mem  [DEPTH];
    logic [DATA_W-1:0]    wdata_mem [DEPTH];
    logic [FE_NBYTES-1:0] wstrb_mem [DEPTH];

    logic [DEPTH_W:0] wr_ptr_q;
    logic [DEPTH_W:0] rd_ptr_q;
    logic [DEPTH_W:0] level_q;
    logic             overflow_q;

    logic empty;
    logic full;
    logic push_acc;
    logic pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[DEPTH_W-1:0] == rd_ptr_q[DEPTH_W-1:0]) &&
                      (wr_ptr_q[DEPTH_W] != rd_ptr_q[DEPTH_W]);
    assign push_acc = bus.push_i & ~full;
    assign pop      = ~empty & bus.ready_i;

    always_ff @(posedge clk_i) begin
        if (push_acc) begin
            addr_mem[wr_ptr_q[DEPTH_W-1:0]]  <= bus.push_addr_i;
            wdata_mem[wr_ptr_q[DEPTH_W-1:0]] <= bus.push_wdata_i;
            wstrb_mem[wr_ptr_q[DEPTH_W-1:0]] <= bus.push_wstrb_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_acc) wr_ptr_q <= wr_ptr_q + ONE;
            if (pop)      rd_ptr_q <= rd_ptr_q + ONE;
            case ({push_acc, pop})
                2'b10:   level_q <= level_q + ONE;
                2'b01:   level_q <= level_q - ONE;
                default: level_q <= level_q;
            endcase
            // Full is judged before the edge, so a push alongside a pop still drops.
            if (bus.push_i && full) overflow_q <= 1'b1;
        end
    end

    assign bus.full_o     = full;
    assign bus.empty_o    = empty;
    assign bus.valid_o    = ~empty;
    assign bus.level_o    = level_q;
    assign bus.overflow_o = overflow_q;
    assign bus.addr_o     = addr_mem[rd_ptr_q[DEPTH_W-1:0]];
    assign bus.wdata_o    = wdata_mem[rd_ptr_q[DEPTH_W-1:0]];
    assign bus.wstrb_o    = wstrb_mem[rd_ptr_q[DEPTH_W-1:0]];
endmodule

// File: tb/tb_iob_cache_write_buffer.sv
// Directed bench for iob_cache_write_buffer: stimulus queues expected head
// entries, a negedge monitor compares every transfer against that queue.
module tb_iob_cache_write_buffer;
  localparam int ADDR_W  = 24;
  localparam int DATA_W  = 32;
  localparam int DEPTH_W = 2;
  localparam int WORD_W  = ADDR_W - 2;
  localparam int ENT_W   = WORD_W + DATA_W + 4;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;
  logic [ENT_W-1:0] exp_q[$];

  iob_cache_write_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_W(DEPTH_W)) bus ();

  iob_cache_write_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_W(DEPTH_W)) dut (
    .clk_i (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "bench timed out");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: each transfer must match the oldest queued entry
  always @(negedge clk) begin
    if (!reset && bus.valid_o && bus.ready_i) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL head_unexpected: got 0x%0h required no transfer",
                 {bus.addr_o, bus.wdata_o, bus.wstrb_o});
      end else begin
        logic [ENT_W-1:0] e;
        e = exp_q.pop_front();
        if ({bus.addr_o, bus.wdata_o, bus.wstrb_o} !== e) begin
          n_fail++;
          $display("FAIL head_data: got 0x%0h required 0x%0h",
                   {bus.addr_o, bus.wdata_o, bus.wstrb_o}, e);
        end
      end
    end
  end

  // driver tasks: all start and end one time unit after a rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [WORD_W-1:0] a, input logic [31:0] d,
                           input logic [3:0] s, input bit accepted);
    bus.push_i       = 1'b1;
    bus.push_addr_i  = a;
    bus.push_wdata_i = d;
    bus.push_wstrb_i = s;
    if (accepted) exp_q.push_back({a, d, s});
    step();
    bus.push_i = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    bus.ready_i = 1'b1;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      if (bus.empty_o) done = 1'b1;
    end
    chk("drain_empty", 64'(bus.empty_o), 64'd1);
    chk("drain_queue_left", 64'(exp_q.size()), 64'd0);
    step();
    bus.ready_i = 1'b0;
  endtask

  initial begin
    n_cmp            = 0;
    n_fail           = 0;
    reset            = 1'b1;
    bus.push_i       = 1'b0;
    bus.push_addr_i  = '0;
    bus.push_wdata_i = '0;
    bus.push_wstrb_i = '0;
    bus.ready_i      = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_empty", 64'(bus.empty_o), 64'd1);
    chk("rst_full", 64'(bus.full_o), 64'd0);
    chk("rst_valid", 64'(bus.valid_o), 64'd0);
    chk("rst_level", 64'(bus.level_o), 64'd0);
    chk("rst_overflow", 64'(bus.overflow_o), 64'd0);
    step();
    reset = 1'b0;
    step();

    // single push, head held while ready is low
    push_word(22'h000010, 32'hDEADBEEF, 4'hF, 1'b1);
    @(negedge clk);
    chk("one_valid", 64'(bus.valid_o), 64'd1);
    chk("one_addr", 64'(bus.addr_o), 64'h10);
    chk("one_wdata", 64'(bus.wdata_o), 64'hDEADBEEF);
    chk("one_wstrb", 64'(bus.wstrb_o), 64'hF);
    chk("one_level", 64'(bus.level_o), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_addr", 64'(bus.addr_o), 64'h10);
      chk("hold_wdata", 64'(bus.wdata_o), 64'hDEADBEEF);
    end
    step();
    drain();

    // fill to full, overflow push dropped
    for (int i = 1; i <= 4; i++)
      push_word(WORD_W'(32'h100 + i), 32'(i), 4'(i), 1'b1);
    @(negedge clk);
    chk("fill_full", 64'(bus.full_o), 64'd1);
    chk("fill_level", 64'(bus.level_o), 64'd4);
    chk("fill_overflow_pre", 64'(bus.overflow_o), 64'd0);
    step();
    push_word(22'h000105, 32'h5, 4'h5, 1'b0);
    @(negedge clk);
    chk("ovf_flag", 64'(bus.overflow_o), 64'd1);
    chk("ovf_level", 64'(bus.level_o), 64'd4);
    step();
    drain();

    // streaming: prefill one entry, then push and pop every cycle
    push_word(22'h000200, 32'h100, 4'h3, 1'b1);
    bus.ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.push_i       = 1'b1;
      bus.push_addr_i  = WORD_W'(32'h201 + i);
      bus.push_wdata_i = 32'h200 + 32'(i);
      bus.push_wstrb_i = 4'(i);
      exp_q.push_back({WORD_W'(32'h201 + i), 32'h200 + 32'(i), 4'(i)});
      @(negedge clk);
      chk("stream_level", 64'(bus.level_o), 64'd1);
      chk("stream_full", 64'(bus.full_o), 64'd0);
      step();
    end
    bus.push_i = 1'b0;
    drain();

    // asynchronous reset in the middle of a pop
    for (int i = 0; i < 3; i++)
      push_word(WORD_W'(32'h300 + i), 32'h3000 + 32'(i), 4'hF, 1'b1);
    bus.ready_i = 1'b1;
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 64'(bus.valid_o), 64'd0);
    chk("arst_empty", 64'(bus.empty_o), 64'd1);
    chk("arst_level", 64'(bus.level_o), 64'd0);
    chk("arst_full", 64'(bus.full_o), 64'd0);
    chk("arst_overflow", 64'(bus.overflow_o), 64'd0);
    exp_q.delete();
    bus.ready_i = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    push_word(22'h00003C, 32'hA5A5A5A5, 4'hF, 1'b1);
    @(negedge clk);
    chk("post_rst_wdata", 64'(bus.wdata_o), 64'hA5A5A5A5);
    chk("post_rst_level", 64'(bus.level_o), 64'd1);
    step();

    // full with simultaneous push and pop: pop happens, push dropped
    for (int i = 1; i <= 3; i++)
      push_word(WORD_W'(32'h400 + i), 32'hC0 + 32'(i), 4'h1, 1'b1);
    @(negedge clk);
    chk("fullpp_full", 64'(bus.full_o), 64'd1);
    chk("fullpp_level_pre", 64'(bus.level_o), 64'd4);
    step();
    bus.push_i       = 1'b1;
    bus.push_addr_i  = 22'h000BAD;
    bus.push_wdata_i = 32'h00000BAD;
    bus.push_wstrb_i = 4'hF;
    bus.ready_i      = 1'b1;
    step();
    bus.push_i  = 1'b0;
    bus.ready_i = 1'b0;
    @(negedge clk);
    chk("fullpp_level", 64'(bus.level_o), 64'd3);
    chk("fullpp_overflow", 64'(bus.overflow_o), 64'd1);
    chk("fullpp_full_post", 64'(bus.full_o), 64'd0);
    chk("fullpp_head", 64'(bus.wdata_o), 64'hC1);
    step();
    drain();

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
